div_arbiter_ctrl: RTL and testbench

- Shares one iterative restoring divider between NREQ requesters.
- Round-robin arbitration; the winner's operands are captured and the shift-subtract divider is sequenced one bit per cycle.
- The result is returned on a shared result bus tagged with the requester id.
- Sits between several arithmetic clients and a single divide resource, replacing per-client combinational dividers.

---
 rtl/div_arb_pkg.sv | 14 +
 rtl/div_iter_core.sv | 49 ++++
 rtl/div_arbiter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_div_arbiter_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - shared state encoding, size defaults and divide-by-zero quotient
package div_arb_pkg;
  localparam int W_DEFAULT    = 4;
  localparam int NREQ_DEFAULT = 4;

  // Sliced to the operand width by users; W is assumed <= 64.
  localparam logic [63:0] DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - restoring shift-subtract divider datapath, one quotient bit per step
// q/r present the post-step value so the owner can capture the final result on the last step edge.
module div_iter_core
  import div_arb_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r
);
  // Quotient bits enter the dividend register from the LSB as dividend bits leave at the MSB.
  logic [W-1:0] r_rem;
  logic [W-1:0] r_dvd;
  logic [W-1:0] r_div;

  logic [W:0]   w_rem_s;
  logic         w_ge;
  logic [W-1:0] w_rem_n;
  logic [W-1:0] w_dvd_n;

  assign w_rem_s = {r_rem, r_dvd[W-1]};
  assign w_ge    = (w_rem_s >= {1'b0, r_div});
  assign w_rem_n = w_ge ? (w_rem_s[W-1:0] - r_div) : w_rem_s[W-1:0];
  assign w_dvd_n = {r_dvd[W-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_dvd <= '0;
      r_div <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_dvd <= a;
      r_div <= b;
    end else if (step) begin
      r_rem <= w_rem_n;
      r_dvd <= w_dvd_n;
    end
  end

  assign q = w_dvd_n;
  assign r = w_rem_n;
endmodule

// File: rtl/div_arbiter_ctrl.sv
// rtl/div_arbiter_ctrl.sv - arbitrates NREQ requesters onto one iterative divider
// Optional DIV_ARB_FIXED_PRIO_EN: lowest index always wins instead of round-robin.
module div_arbiter_ctrl
  import div_arb_pkg::*;
#(
  parameter int W    = W_DEFAULT,
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [W-1:0]      q,
  output logic [W-1:0]      r,
  output logic              dz
);
  localparam int CW = $clog2(W + 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;
  logic            r_done;
  logic [IDW-1:0]  r_done_id;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_r;
  logic            r_dz;
  logic [IDW-1:0]  r_owner;
  logic [W-1:0]    r_a_hold;
  logic            r_dz_pend;
`ifndef DIV_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]  r_ptr;
`endif

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_load;
  logic            w_step;
  logic [W-1:0]    w_core_q;
  logic [W-1:0]    w_core_r;

  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef DIV_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(r_ptr) + k) % NREQ;
`endif
      if (!w_found && req[IDW'(idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  assign w_a    = a_bus[w_win*W +: W];
  assign w_b    = b_bus[w_win*W +: W];
  assign w_load = (r_state == IDLE) && w_found;
  assign w_step = (r_state == RUN);

  div_iter_core #(.W(W)) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .step (w_step),
    .a    (w_a),
    .b    (w_b),
    .q    (w_core_q),
    .r    (w_core_r)
  );

  // A zero divisor spends its grant cycle in DONE with the result pending, so done lands at T+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_dz      <= 1'b0;
      r_owner   <= '0;
      r_a_hold  <= '0;
      r_dz_pend <= 1'b0;
`ifndef DIV_ARB_FIXED_PRIO_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_gnt  <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_gnt    <= NREQ'(1) << w_win;
            r_busy   <= 1'b1;
            r_owner  <= w_win;
            r_a_hold <= w_a;
`ifndef DIV_ARB_FIXED_PRIO_EN
            r_ptr    <= IDW'((int'(w_win) + 1) % NREQ);
`endif
            if (w_b == '0) begin
              r_state   <= DONE;
              r_dz_pend <= 1'b1;
            end else begin
              r_state <= RUN;
              r_cnt   <= CW'(W);
            end
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state   <= DONE;
            r_done    <= 1'b1;
            r_q       <= w_core_q;
            r_r       <= w_core_r;
            r_dz      <= 1'b0;
            r_done_id <= r_owner;
          end
        end
        DONE: begin
          if (r_dz_pend) begin
            r_dz_pend <= 1'b0;
            r_done    <= 1'b1;
            r_q       <= DZ_QUOTIENT[W-1:0];
            r_r       <= r_a_hold;
            r_dz      <= 1'b1;
            r_done_id <= r_owner;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign q       = r_q;
  assign r       = r_r;
  assign dz      = r_dz;
endmodule

// File: tb/tb_div_arbiter_ctrl.sv
// tb/tb_div_arbiter_ctrl.sv - directed vector bench for div_arbiter_ctrl (W=4, NREQ=4)
module tb_div_arbiter_ctrl;
  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  q;
  logic [3:0]  r;
  logic        dz;

  int n_chk;
  int n_err;
  logic prev_busy;
  int exp_order[5];

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] eq;
    logic [3:0] er;
    logic       edz;
  } vec_t;

  vec_t tv[7];

  div_arbiter_ctrl #(.W(4), .NREQ(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_bus   (a_bus),
    .b_bus   (b_bus),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .q       (q),
    .r       (r),
    .dz      (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (gnt != 4'b0) begin
      chk("gnt_after_busy", int'(prev_busy), 0);
      chk("gnt_onehot", $countones(gnt), 1);
    end
    prev_busy = busy;
  endtask

  task automatic do_div(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic edz);
    int lat;
    req = 4'b0001 << id;
    a_bus[id*4 +: 4] = a;
    b_bus[id*4 +: 4] = b;
    tick();
    chk("grant", int'(gnt), int'(4'b0001 << id));
    chk("busy_at_grant", int'(busy), 1);
    req = 4'b0;
    a_bus[id*4 +: 4] = ~a;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, (b == 4'd0) ? 2 : 5);
    chk("q", int'(q), int'(eq));
    chk("r", int'(r), int'(er));
    chk("done_id", int'(done_id), id);
    chk("dz", int'(dz), int'(edz));
    tick();
    chk("done_pulse", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    chk("q_hold", int'(q), int'(eq));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rr_run(input logic [3:0] rq, input int n);
    int t;
    int id;
    for (int i = 0; i < 4; i++) begin
      a_bus[i*4 +: 4] = 4'(i + 8);
      b_bus[i*4 +: 4] = 4'(i + 1);
    end
    req = rq;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (gnt == 4'b0 && t < 30) begin
        tick();
        t++;
      end
      id = -1;
      for (int i = 0; i < 4; i++) if (gnt[i]) id = i;
      chk("rr_grant_id", id, exp_order[k]);
      t = 0;
      while (!done && t < 30) begin
        tick();
        t++;
      end
      chk("rr_done_seen", int'(done), 1);
      chk("rr_done_id", int'(done_id), id);
      if (id >= 0) chk("rr_q", int'(q), (id + 8) / (id + 1));
    end
    req = 4'b0;
    t = 0;
    while (busy && t < 30) begin
      tick();
      t++;
    end
  endtask

  initial begin
    int cnt;
    n_chk = 0;
    n_err = 0;
    prev_busy = 1'b0;
    rst = 1'b1;
    req = 4'b0;
    a_bus = '0;
    b_bus = '0;

    tv[0] = '{id: 2, a: 4'd13, b: 4'd3, eq: 4'd4,  er: 4'd1, edz: 1'b0};
    tv[1] = '{id: 1, a: 4'd9,  b: 4'd0, eq: 4'd15, er: 4'd9, edz: 1'b1};
    tv[2] = '{id: 0, a: 4'd15, b: 4'd1, eq: 4'd15, er: 4'd0, edz: 1'b0};
    tv[3] = '{id: 3, a: 4'd2,  b: 4'd7, eq: 4'd0,  er: 4'd2, edz: 1'b0};
    tv[4] = '{id: 2, a: 4'd7,  b: 4'd7, eq: 4'd1,  er: 4'd0, edz: 1'b0};
    tv[5] = '{id: 1, a: 4'd14, b: 4'd4, eq: 4'd3,  er: 4'd2, edz: 1'b0};
    tv[6] = '{id: 3, a: 4'd11, b: 4'd0, eq: 4'd15, er: 4'd11, edz: 1'b1};

    tick();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_dz", int'(dz), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_div(tv[i].id, tv[i].a, tv[i].b, tv[i].eq, tv[i].er, tv[i].edz);

    req = 4'b0100;
    a_bus[8 +: 4] = 4'd13;
    b_bus[8 +: 4] = 4'd3;
    tick();
    chk("abort_grant", int'(gnt), 4);
    req = 4'b0;
    tick();
    chk("abort_busy_run", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(q), 0);
    chk("abort_r", int'(r), 0);
    chk("abort_dz", int'(dz), 0);
    chk("abort_done", int'(done), 0);
    tick();
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      tick();
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    do_div(0, 4'd6, 4'd4, 4'd1, 4'd2, 1'b0);

    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    rr_run(4'b1111, 5);

    do_reset();
`ifdef DIV_ARB_FIXED_PRIO_EN
    exp_order = '{1, 1, 1, 1, 1};
`else
    exp_order = '{1, 3, 1, 3, 1};
`endif
    rr_run(4'b1010, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
